// File: rtl/qos_planificador_pkg.sv
// Shared types and widths for the QoS scheduler.
// Mode codes, FSM states and field widths used by all files.
package qos_planificador_pkg;

  localparam int QUEUE_QUANTITY    = 4;
  localparam int MAX_WEIGHT        = 64;
  localparam int TABLE_SIZE        = 8;
  localparam int TIPOS_ROUND_ROBIN = 3;

  localparam int W_PESO = $clog2(MAX_WEIGHT);
  localparam int W_Q    = $clog2(QUEUE_QUANTITY);
  localparam int W_T    = $clog2(TABLE_SIZE);
  localparam int W_MODO = $clog2(TIPOS_ROUND_ROBIN);

  localparam logic [W_MODO-1:0] RR_NORMAL    = W_MODO'(0);
  localparam logic [W_MODO-1:0] RR_PESADO    = W_MODO'(1);
  localparam logic [W_MODO-1:0] RR_ARBITRADO = W_MODO'(2);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_SELECT,
    ST_SERVE
  } estado_e;

  function automatic logic [QUEUE_QUANTITY-1:0] a_onehot(
    input logic [W_Q-1:0] i
  );
    a_onehot    = '0;
    a_onehot[i] = 1'b1;
  endfunction

endpackage

// File: rtl/qos_planificador_if.sv
// Handshake bundle between scheduler, VC FIFO bank and output FIFO.
// master = scheduler: drives pop/push_salida/vc_sel/idle, sees flags.
interface qos_planificador_if;
  import qos_planificador_pkg::*;

  logic [QUEUE_QUANTITY-1:0] fifo_empty;
  logic                      salida_full;
  logic [QUEUE_QUANTITY-1:0] pop;
  logic                      push_salida;
  logic [W_Q-1:0]            vc_sel;
  logic                      idle;

  modport master (
    input  fifo_empty, salida_full,
    output pop, push_salida, vc_sel, idle
  );

  modport slave (
    output fifo_empty, salida_full,
    input  pop, push_salida, vc_sel, idle
  );

endinterface

// File: rtl/qos_buscador_rr.sv
// Rotate-priority finder: first set req bit at or after inicio.
// Ports: req, inicio in; encontrado, indice out. N must be 2**W.
module qos_buscador_rr #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] inicio,
  output logic         encontrado,
  output logic [W-1:0] indice
);

  always_comb begin
    logic [W-1:0] k;
    encontrado = 1'b0;
    indice     = '0;
    k          = '0;
    // scan from the farthest offset down so the nearest hit wins
    for (int i = N - 1; i >= 0; i--) begin
      k = inicio + W'(i);
      if (req[k]) begin
        encontrado = 1'b1;
        indice     = k;
      end
    end
  end

endmodule

// File: rtl/qos_planificador.sv
// QoS scheduler: picks the VC FIFO to pop (RR, weighted, table modes).
// Ports: clk, rst(sync low), enb, iniciar, mem_* config, bus (master).
module qos_planificador
  import qos_planificador_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enb,
  input  logic                             iniciar,
  input  logic [W_MODO-1:0]                mem_seleccion_roundRobin,
  input  logic [QUEUE_QUANTITY*W_PESO-1:0] mem_pesos,
  input  logic [TABLE_SIZE*W_PESO-1:0]     mem_pesosArbitraje,
  input  logic [TABLE_SIZE*W_Q-1:0]        mem_selecciones,
  qos_planificador_if.master               bus
);

  estado_e                          estado_q, estado_d;
  logic [W_MODO-1:0]                modo_q, modo_d;
  logic [QUEUE_QUANTITY*W_PESO-1:0] pesos_q, pesos_d;
  logic [TABLE_SIZE*W_PESO-1:0]     arb_q, arb_d;
  logic [TABLE_SIZE*W_Q-1:0]        sel_q, sel_d;
  logic [W_Q-1:0]                   qptr_q, qptr_d;
  logic [W_T-1:0]                   tptr_q, tptr_d;
  logic [W_PESO-1:0]                cnt_q, cnt_d;
  logic [W_Q-1:0]                   cola_q, cola_d;
  logic [W_T-1:0]                   ent_q, ent_d;
  logic                             push_q, push_d;
  logic [W_Q-1:0]                   vcsel_q, vcsel_d;

  logic                      es_pesado, es_tabla;
  logic [QUEUE_QUANTITY-1:0] req_q;
  logic [TABLE_SIZE-1:0]     req_t;
  logic                      q_hay, t_hay;
  logic [W_Q-1:0]            q_idx;
  logic [W_T-1:0]            t_idx;
  logic [QUEUE_QUANTITY-1:0] pop_c;
  logic                      idle_c, salir;

  // mode 3 falls through to plain round robin
  assign es_pesado = (modo_q == RR_PESADO);
  assign es_tabla  = (modo_q == RR_ARBITRADO);

  always_comb begin
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      req_q[i] = !bus.fifo_empty[i] &&
                 (!es_pesado ||
                  pesos_q[i*W_PESO +: W_PESO] != '0);
    end
  end

  always_comb begin
    for (int k = 0; k < TABLE_SIZE; k++) begin
      req_t[k] = (arb_q[k*W_PESO +: W_PESO] != '0) &&
                 !bus.fifo_empty[sel_q[k*W_Q +: W_Q]];
    end
  end

  qos_buscador_rr #(.N(QUEUE_QUANTITY)) u_busca_cola (
    .req        (req_q),
    .inicio     (qptr_q),
    .encontrado (q_hay),
    .indice     (q_idx)
  );

  qos_buscador_rr #(.N(TABLE_SIZE)) u_busca_tabla (
    .req        (req_t),
    .inicio     (tptr_q),
    .encontrado (t_hay),
    .indice     (t_idx)
  );

  always_comb begin
    estado_d = estado_q;
    modo_d   = modo_q;
    pesos_d  = pesos_q;
    arb_d    = arb_q;
    sel_d    = sel_q;
    qptr_d   = qptr_q;
    tptr_d   = tptr_q;
    cnt_d    = cnt_q;
    cola_d   = cola_q;
    ent_d    = ent_q;
    pop_c    = '0;
    idle_c   = 1'b0;
    salir    = 1'b0;

    unique case (estado_q)
      ST_INIT: begin
        idle_c = 1'b1;
        if (iniciar) begin
          modo_d   = mem_seleccion_roundRobin;
          pesos_d  = mem_pesos;
          arb_d    = mem_pesosArbitraje;
          sel_d    = mem_selecciones;
          estado_d = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (es_tabla) begin
          idle_c = !t_hay && !push_q;
          if (t_hay) begin
            ent_d    = t_idx;
            cola_d   = sel_q[t_idx*W_Q +: W_Q];
            cnt_d    = arb_q[t_idx*W_PESO +: W_PESO];
            estado_d = ST_SERVE;
          end
        end else begin
          idle_c = !q_hay && !push_q;
          if (q_hay) begin
            cola_d   = q_idx;
            cnt_d    = es_pesado ?
                       pesos_q[q_idx*W_PESO +: W_PESO] :
                       W_PESO'(1);
            estado_d = ST_SERVE;
          end
        end
      end
      ST_SERVE: begin
        if (bus.fifo_empty[cola_q]) begin
          salir = 1'b1;
        end else if (!bus.salida_full) begin
          pop_c = a_onehot(cola_q);
          cnt_d = cnt_q - W_PESO'(1);
          salir = (cnt_q == W_PESO'(1));
        end
      end
      default: estado_d = ST_INIT;
    endcase

    if (salir) begin
      estado_d = ST_SELECT;
      if (es_tabla) tptr_d = ent_q + W_T'(1);
      else          qptr_d = cola_q + W_Q'(1);
    end

    // a pop during reset or freeze would lose the word
    if (!enb || !rst) pop_c = '0;

    push_d  = |pop_c;
    vcsel_d = cola_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      estado_q <= ST_INIT;
      modo_q   <= '0;
      pesos_q  <= '0;
      arb_q    <= '0;
      sel_q    <= '0;
      qptr_q   <= '0;
      tptr_q   <= '0;
      cnt_q    <= '0;
      cola_q   <= '0;
      ent_q    <= '0;
      push_q   <= 1'b0;
      vcsel_q  <= '0;
    end else if (enb) begin
      estado_q <= estado_d;
      modo_q   <= modo_d;
      pesos_q  <= pesos_d;
      arb_q    <= arb_d;
      sel_q    <= sel_d;
      qptr_q   <= qptr_d;
      tptr_q   <= tptr_d;
      cnt_q    <= cnt_d;
      cola_q   <= cola_d;
      ent_q    <= ent_d;
      push_q   <= push_d;
      vcsel_q  <= vcsel_d;
    end
  end

  assign bus.pop         = pop_c;
  assign bus.push_salida = push_q & enb;
  assign bus.vc_sel      = vcsel_q;
  assign bus.idle        = idle_c;

endmodule

// File: tb/tb_qos_planificador.sv
// Bench for qos_planificador: FIFO occupancy model plus pop-order
// scoreboard; each pop is matched to the queue of expected VCs.
module tb_qos_planificador;
  import qos_planificador_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enb = 1'b1;
  logic iniciar = 1'b0;
  logic [W_MODO-1:0]                modo  = '0;
  logic [QUEUE_QUANTITY*W_PESO-1:0] pesos = '0;
  logic [TABLE_SIZE*W_PESO-1:0]     arb   = '0;
  logic [TABLE_SIZE*W_Q-1:0]        sels  = '0;

  int cnt [QUEUE_QUANTITY];
  int exp_q [$];
  int n_pass = 0;
  int n_tot = 0;
  int cyc = 0;
  int last_pop = 0;
  int gap_min = 0;
  int gap_max = 0;
  int pops_seen = 0;
  bit push_pend = 1'b0;
  int push_idx = 0;

  qos_planificador_if bus();

  qos_planificador dut (
    .clk                      (clk),
    .rst                      (rst),
    .enb                      (enb),
    .iniciar                  (iniciar),
    .mem_seleccion_roundRobin (modo),
    .mem_pesos                (pesos),
    .mem_pesosArbitraje       (arb),
    .mem_selecciones          (sels),
    .bus                      (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < QUEUE_QUANTITY; i++)
      bus.fifo_empty[i] = (cnt[i] == 0);
  end

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] want);
    n_tot++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %0d want %0d", tag, got, want);
  endtask

  task automatic push_n(int q, int n);
    repeat (n) exp_q.push_back(q);
  endtask

  task automatic set_cnt(int a, int b, int c, int d);
    cnt[0] = a; cnt[1] = b; cnt[2] = c; cnt[3] = d;
  endtask

  task automatic cycle();
    logic [QUEUE_QUANTITY-1:0] p;
    int idx;
    idx = 0;
    @(negedge clk);
    cyc++;
    p = bus.pop;
    chk("push_salida", bus.push_salida, push_pend);
    if (push_pend) chk("vc_sel", bus.vc_sel, push_idx);
    if (p != '0) begin
      for (int i = 0; i < QUEUE_QUANTITY; i++)
        if (p[i]) idx = i;
      chk("pop_onehot", $countones(p), 1);
      chk("pop_nonempty", cnt[idx] > 0, 1);
      chk("pop_while_full", bus.salida_full, 0);
      if (exp_q.size() > 0) chk("pop_q", idx, exp_q.pop_front());
      else chk("pop_q", idx, -1);
      if (gap_max > 0 && last_pop > 0) begin
        chk("gap_min", (cyc - last_pop) >= gap_min, 1);
        chk("gap_max", (cyc - last_pop) <= gap_max, 1);
      end
      last_pop = cyc;
      pops_seen++;
    end
    @(posedge clk);
    push_pend = (p != '0);
    push_idx  = idx;
    #1;
    for (int i = 0; i < QUEUE_QUANTITY; i++)
      if (p[i] && cnt[i] > 0) cnt[i]--;
  endtask

  task automatic drain(int lim);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < lim) begin
      cycle();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (4) cycle();
    chk("idle_end", bus.idle, 1);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) cycle();
    rst = 1'b1;
    gap_min = 0;
    gap_max = 0;
    last_pop = 0;
    pops_seen = 0;
  endtask

  task automatic start();
    iniciar = 1'b1;
    cycle();
    iniciar = 1'b0;
  endtask

  task automatic wait_pops(int want, int lim);
    int n;
    n = 0;
    while (pops_seen < want && n < lim) begin
      cycle();
      n++;
    end
    chk("wait_pops", pops_seen, want);
  endtask

  initial begin
    int pw [QUEUE_QUANTITY];
    int ts [TABLE_SIZE];
    int tp [TABLE_SIZE];
    bus.salida_full = 1'b0;

    // reset held while iniciar pulses: nothing moves
    set_cnt(3, 3, 3, 3);
    iniciar = 1'b1;
    repeat (4) begin
      cycle();
      chk("rst_pop", bus.pop, 0);
      chk("rst_push", bus.push_salida, 0);
      chk("rst_idle", bus.idle, 1);
    end
    iniciar = 1'b0;

    // released without iniciar: still idle in INIT
    rst = 1'b1;
    repeat (4) begin
      cycle();
      chk("init_pop", bus.pop, 0);
      chk("init_idle", bus.idle, 1);
    end

    // mode 0: plain round robin, two words per queue
    set_cnt(2, 2, 2, 2);
    modo = RR_NORMAL;
    start();
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < 4; q++) push_n(q, 1);
    gap_min = 2;
    gap_max = 2;
    last_pop = 0;
    drain(40);

    // mode 1: weights q0..q3 = 6,1,4,2, full stall mid q0 burst
    do_reset();
    pw = '{6, 1, 4, 2};
    for (int i = 0; i < QUEUE_QUANTITY; i++)
      pesos[i*W_PESO +: W_PESO] = W_PESO'(pw[i]);
    set_cnt(8, 8, 8, 8);
    modo = RR_PESADO;
    start();
    push_n(0, 6); push_n(1, 1); push_n(2, 4); push_n(3, 2);
    push_n(0, 2); push_n(1, 1); push_n(2, 4); push_n(3, 2);
    push_n(1, 1); push_n(3, 2);
    push_n(1, 1); push_n(3, 2);
    push_n(1, 4);
    wait_pops(2, 20);
    bus.salida_full = 1'b1;
    repeat (3) begin
      #1 chk("full_pop", bus.pop, 0);
      cycle();
    end
    bus.salida_full = 1'b0;
    drain(200);

    // mode 1: weight-0 queue is never served
    do_reset();
    pw = '{1, 0, 2, 1};
    for (int i = 0; i < QUEUE_QUANTITY; i++)
      pesos[i*W_PESO +: W_PESO] = W_PESO'(pw[i]);
    set_cnt(2, 2, 2, 2);
    modo = RR_PESADO;
    start();
    push_n(0, 1); push_n(2, 2); push_n(3, 1);
    push_n(0, 1); push_n(3, 1);
    drain(60);
    chk("w0_untouched", cnt[1], 2);

    // mode 2: table order, entry 5 (q0 empty) skipped
    do_reset();
    ts = '{2, 1, 2, 2, 1, 0, 2, 3};
    tp = '{4, 2, 2, 2, 2, 2, 2, 2};
    for (int k = 0; k < TABLE_SIZE; k++) begin
      sels[k*W_Q +: W_Q]       = W_Q'(ts[k]);
      arb[k*W_PESO +: W_PESO]  = W_PESO'(tp[k]);
    end
    set_cnt(0, 4, 10, 2);
    modo = RR_ARBITRADO;
    start();
    push_n(2, 4); push_n(1, 2); push_n(2, 2); push_n(2, 2);
    push_n(1, 2); push_n(2, 2); push_n(3, 2);
    gap_min = 1;
    gap_max = 2;
    last_pop = 0;
    drain(80);

    // reset mid-burst, then restart from q0
    do_reset();
    pw = '{3, 3, 3, 3};
    for (int i = 0; i < QUEUE_QUANTITY; i++)
      pesos[i*W_PESO +: W_PESO] = W_PESO'(pw[i]);
    set_cnt(8, 8, 8, 8);
    modo = RR_PESADO;
    start();
    push_n(0, 3); push_n(1, 1);
    wait_pops(4, 20);
    rst = 1'b0;
    #1 chk("mid_rst_pop", bus.pop, 0);
    cycle();
    chk("mid_rst_push", bus.push_salida, 0);
    chk("mid_rst_idle", bus.idle, 1);
    rst = 1'b1;
    cycle();
    chk("post_rst_pop", bus.pop, 0);
    set_cnt(1, 1, 1, 1);
    modo = RR_NORMAL;
    start();
    push_n(0, 1); push_n(1, 1); push_n(2, 1); push_n(3, 1);
    drain(40);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/qos_planificador.md
Name: qos_planificador

Overview:
- Scheduler for the QoS block: decides which of the QUEUE_QUANTITY virtual-channel FIFOs is popped next and pushes that word into the output FIFO.
- Three service disciplines, chosen by mem_seleccion_roundRobin:
  - 0: plain round robin
  - 1: weighted round robin
  - 2: table-arbitrated round robin
- Sits between the per-VC FIFO bank and fifoSalida. It drives their read/write enables and the VC-select mux; it never touches data.

Parameters:
- QUEUE_QUANTITY, 4: number of VC FIFOs.
- MAX_WEIGHT, 64: weight range; weight fields are $clog2(MAX_WEIGHT)=6 bits.
- TABLE_SIZE, 8: entries in the arbitration table.
- TIPOS_ROUND_ROBIN, 3: number of modes; mode field is $clog2(TIPOS_ROUND_ROBIN)=2 bits.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low.
- enb  in  1  global enable; 0 freezes all state.
- iniciar  in  1  one-cycle pulse; latches configuration and starts scheduling.
- mem_seleccion_roundRobin  in  2  mode: 0 RR, 1 weighted, 2 table, 3 = treated as 0.
- mem_pesos  in  QUEUE_QUANTITY*6  per-queue weight; queue i occupies bits [6i+5:6i].
- mem_pesosArbitraje  in  TABLE_SIZE*6  per-entry burst length; entry k occupies [6k+5:6k].
- mem_selecciones  in  TABLE_SIZE*2  per-entry queue index; entry k occupies [2k+1:2k].
- fifo_empty  in  QUEUE_QUANTITY  empty flags of the VC FIFOs.
- salida_full  in  1  full flag of the output FIFO.
- pop  out  QUEUE_QUANTITY  one-hot read enable to the VC FIFOs.
- push_salida  out  1  write enable to the output FIFO.
- vc_sel  out  2  mux select for the output FIFO data; valid while push_salida=1.
- idle  out  1  scheduler has nothing to do.

Behaviour:
- Reset (rst=0 at posedge):
  - Outputs: pop=0, push_salida=0, vc_sel=0, idle=1.
  - State: INIT; queue pointer=0, table pointer=0, burst counter=0; shadow configuration cleared to 0.
  - Reset mid-burst drops any pending push.
- enb=0: no state change; pop and push_salida are forced to 0.
- States:
  - INIT: no pops. iniciar=1 latches mode, pesos, pesosArbitraje and selecciones into shadow registers, then goes to SELECT. Configuration changes are ignored outside this latch.
  - SELECT: in one cycle, search for the next eligible candidate.
    - Mode 0/3: queue pointer upward with wrap; eligible = !fifo_empty.
    - Mode 1: as mode 0, but a queue with weight 0 is never eligible.
    - Mode 2: table pointer upward with wrap; eligible = pesosArbitraje[k]!=0 and !fifo_empty[selecciones[k]].
    - If found: load the burst counter (1 in mode 0; weight in mode 1; pesosArbitraje[k] in mode 2) and go to SERVE with the current queue = the candidate.
    - If not found: stay in SELECT with idle=1.
  - SERVE: each cycle with !fifo_empty[q] and !salida_full, assert pop[q] and decrement the counter.
    - salida_full=1: pop=0 and the counter holds.
    - Exit to SELECT when the counter reaches 0 or fifo_empty[q]=1.
    - On exit, the pointer (queue or table) advances to current+1 mod size.
- Latency: push_salida and vc_sel are registered copies of (|pop, q), one cycle after pop, to match the registered FIFO read data.
- Throughput: one word per cycle within a burst; one SELECT bubble between bursts.
- A pop is never issued to an empty FIFO or while salida_full=1.
- idle=1 in INIT, or in SELECT with no eligible candidate and no push pending. Otherwise idle=0.
- iniciar outside INIT is ignored; reconfiguration requires a reset.

Decomposition:
- Shared package/includes holds:
  - mode constants RR_NORMAL=0, RR_PESADO=1, RR_ARBITRADO=2;
  - state encodings;
  - the width expressions $clog2(MAX_WEIGHT) and $clog2(QUEUE_QUANTITY).
- One sub-module: qos_buscador_rr. It is a combinational rotate-priority finder: inputs are a request vector and a start pointer; outputs are a found flag and an index. It is instantiated for the queue search, and again with TABLE_SIZE width for the table search.

Test Plan:
- Reset held with iniciar pulsed -> pop=0, push_salida=0, idle=1 throughout; after reset release with no iniciar, still no pops.
- Mode 0, all four FIFOs holding 2 words, iniciar -> pop order q0,q1,q2,q3,q0,q1,q2,q3 with one bubble between; push_salida follows each pop by 1 cycle with matching vc_sel; then idle=1.
- Mode 1, pesos={2,4,1,6} (q3..q0), all FIFOs holding 8 words -> bursts of q0×6, q1×1, q2×4, q3×2, repeating; a weight-0 queue is never popped.
- Mode 2, table entries 0..7 = (sel,peso) (2,4),(1,2),(2,2),(2,2),(1,2),(0,2),(2,2),(3,2) -> q2×4, q1×2, q2×2, … in table order; an entry whose queue is empty is skipped without a bubble beyond SELECT.
- salida_full raised for 3 cycles mid-burst in mode 1 -> pop=0 for those cycles, counter held, burst resumes and still totals the weight.
- rst asserted mid-burst -> next cycle pop=0 and push_salida=0, state INIT, pointers 0; a new iniciar restarts from q0.
